// File: rtl/vote_pkg.sv
// Shared types and helpers for the voting-booth session controller.
package vote_pkg;

  localparam int unsigned N_CAND_DEFAULT = 3;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StCommit,
    StRelease,
    StClosed
  } state_e;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      cnt += 32'(v[i]);
    end
    return cnt;
  endfunction

  function automatic logic is_onehot(input logic [31:0] v);
    return popcount(v) == 1;
  endfunction

endpackage

// File: rtl/vote_edge_det.sv
// Registered rising-edge detector used on the officer's arm input.
module vote_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic i_sig,
  output logic o_rise
);

  logic r_sig;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sig <= 1'b0;
    end else begin
      r_sig <= i_sig;
    end
  end

  assign o_rise = i_sig & ~r_sig;

endmodule

// File: rtl/vote_session_ctrl.sv
// Per-voter session controller: one vote per arm, multi-press reject, one-hot vote pulses.
// Optional ARMED timeout enabled by defining VOTE_TIMEOUT_EN.
module vote_session_ctrl
  import vote_pkg::*;
#(
  parameter int unsigned N_CAND      = N_CAND_DEFAULT,
  parameter int unsigned TOTAL_W     = 32,
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_arm,
  input  logic [N_CAND-1:0]  i_btn,
  input  logic               i_close,
  output logic [N_CAND-1:0]  o_vote,
  output logic               o_over,
  output logic               o_ready,
  output logic               o_reject,
  output logic               o_timeout,
  output logic [TOTAL_W-1:0] o_total
);

  state_e              r_state, w_state_d;
  logic                r_voted, w_voted_d;
  logic [N_CAND-1:0]   r_vote;
  logic                r_over, r_ready, r_reject, r_timeout;
  logic [TOTAL_W-1:0]  r_total;
  logic                w_arm_rise;
  logic                w_btn_none, w_btn_one, w_btn_multi;
  logic                w_timeout;

  vote_edge_det u_arm_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .i_sig (i_arm),
    .o_rise(w_arm_rise)
  );

  assign w_btn_none  = (i_btn == '0);
  assign w_btn_one   = is_onehot(32'(i_btn));
  assign w_btn_multi = !w_btn_none && !w_btn_one;

`ifdef VOTE_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt, w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;
  // Close and valid presses win over an expiring timer.
  assign w_timeout = (r_state == StArmed) && w_btn_none && !i_close &&
                     (w_cnt_inc == CNT_W'(TIMEOUT_CYC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if ((w_state_d == StArmed) && (r_state != StArmed)) begin
      r_cnt <= '0;
    end else if ((r_state == StArmed) && w_btn_none) begin
      r_cnt <= w_cnt_inc;
    end
  end
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = (TIMEOUT_CYC != 0);
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_d = r_state;
    w_voted_d = r_voted;
    if ((r_state != StClosed) && i_close) begin
      w_state_d = StClosed;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_arm_rise) w_state_d = StArmed;
        end
        StArmed: begin
          if (w_btn_one) begin
            w_state_d = StCommit;
          end else if (w_btn_multi) begin
            w_state_d = StRelease;
            w_voted_d = 1'b0;
          end else if (w_timeout) begin
            w_state_d = StIdle;
          end
        end
        StCommit: begin
          w_state_d = StRelease;
          w_voted_d = 1'b1;
        end
        StRelease: begin
          if (w_btn_none) w_state_d = r_voted ? StIdle : StArmed;
        end
        StClosed: w_state_d = StClosed;
        default:  w_state_d = StIdle;
      endcase
    end
  end

  // Outputs are decoded from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_voted   <= 1'b0;
      r_vote    <= '0;
      r_over    <= 1'b0;
      r_ready   <= 1'b0;
      r_reject  <= 1'b0;
      r_timeout <= 1'b0;
      r_total   <= '0;
    end else begin
      r_state   <= w_state_d;
      r_voted   <= w_voted_d;
      r_over    <= (w_state_d == StClosed);
      r_ready   <= (w_state_d == StArmed);
      r_reject  <= (r_state == StArmed) && (w_state_d == StRelease);
      r_timeout <= w_timeout;
      if ((r_state == StArmed) && (w_state_d == StCommit)) begin
        r_vote <= i_btn;
        if (r_total != {TOTAL_W{1'b1}}) r_total <= r_total + 1'b1;
      end else begin
        r_vote <= '0;
      end
    end
  end

  assign o_vote    = r_vote;
  assign o_over    = r_over;
  assign o_ready   = r_ready;
  assign o_reject  = r_reject;
  assign o_timeout = r_timeout;
  assign o_total   = r_total;

endmodule

// File: tb/tb_vote_session_ctrl.sv
// Self-checking bench for vote_session_ctrl: directed table, corner sequences, random vs model.
module tb_vote_session_ctrl;

  localparam int unsigned TO_CYC = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_arm;
  logic [2:0]  i_btn;
  logic        i_close;
  logic [2:0]  o_vote;
  logic        o_over, o_ready, o_reject, o_timeout;
  logic [31:0] o_total;

  vote_session_ctrl #(
    .N_CAND     (3),
    .TOTAL_W    (32),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_arm    (i_arm),
    .i_btn    (i_btn),
    .i_close  (i_close),
    .o_vote   (o_vote),
    .o_over   (o_over),
    .o_ready  (o_ready),
    .o_reject (o_reject),
    .o_timeout(o_timeout),
    .o_total  (o_total)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Session-level reference: flags describing where the voter is in the booth flow.
  bit          m_prev_arm, m_closed, m_armed, m_commit, m_wait_release, m_retry;
  int          m_tcnt;
  longint      m_total;
  logic [2:0]  m_vote;
  bit          m_rej, m_to;

  task automatic model_reset();
    m_prev_arm = 0; m_closed = 0; m_armed = 0; m_commit = 0;
    m_wait_release = 0; m_retry = 0; m_tcnt = 0; m_total = 0;
    m_vote = '0; m_rej = 0; m_to = 0;
  endtask

  task automatic model_step(input logic a, input logic [2:0] b, input logic c);
    bit rise;
    int n;
    rise = a && !m_prev_arm;
    m_prev_arm = a;
    n = $countones(b);
    m_vote = '0; m_rej = 0; m_to = 0;
    if (m_closed) begin
      // terminal
    end else if (c) begin
      m_closed = 1; m_armed = 0; m_commit = 0; m_wait_release = 0;
    end else if (m_commit) begin
      m_commit = 0; m_wait_release = 1; m_retry = 0;
    end else if (m_wait_release) begin
      if (n == 0) begin
        m_wait_release = 0;
        if (m_retry) begin m_armed = 1; m_tcnt = 0; end
      end
    end else if (m_armed) begin
      if (n == 1) begin
        m_vote = b; m_armed = 0; m_commit = 1;
        if (m_total < 64'hFFFF_FFFF) m_total++;
      end else if (n > 1) begin
        m_rej = 1; m_armed = 0; m_wait_release = 1; m_retry = 1;
      end else begin
`ifdef VOTE_TIMEOUT_EN
        m_tcnt++;
        if (m_tcnt == int'(TO_CYC)) begin m_to = 1; m_armed = 0; end
`endif
      end
    end else if (rise) begin
      m_armed = 1; m_tcnt = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".vote"},    32'(o_vote),    32'(m_vote));
    chk({tag, ".ready"},   32'(o_ready),   32'(m_armed));
    chk({tag, ".reject"},  32'(o_reject),  32'(m_rej));
    chk({tag, ".over"},    32'(o_over),    32'(m_closed));
    chk({tag, ".timeout"}, 32'(o_timeout), 32'(m_to));
    chk({tag, ".total"},   o_total,        32'(m_total));
  endtask

  // Called at a negedge; leaves the bench at a negedge with reset released.
  task automatic do_reset();
    rst_n = 1'b0; i_arm = 1'b0; i_btn = '0; i_close = 1'b0;
    #1;
    chk("rst.vote",    32'(o_vote),    32'd0);
    chk("rst.ready",   32'(o_ready),   32'd0);
    chk("rst.reject",  32'(o_reject),  32'd0);
    chk("rst.over",    32'(o_over),    32'd0);
    chk("rst.timeout", 32'(o_timeout), 32'd0);
    chk("rst.total",   o_total,        32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic a, input logic [2:0] b, input logic c);
    i_arm = a; i_btn = b; i_close = c;
    @(posedge clk);
    model_step(a, b, c);
    @(negedge clk);
  endtask

  typedef struct {
    logic        arm;
    logic [2:0]  btn;
    logic        close;
    logic [2:0]  vote;
    logic        ready;
    logic        rej;
    logic        over;
    logic [31:0] total;
  } vec_t;

  vec_t tbl[20];

  initial begin
    tbl[0]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'd0};
    tbl[1]  = '{1'b0, 3'b010, 1'b0, 3'b010, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[2]  = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[3]  = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[4]  = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[5]  = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[6]  = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[7]  = '{1'b1, 3'b101, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[8]  = '{1'b1, 3'b101, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 32'd1};
    tbl[9]  = '{1'b1, 3'b101, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd1};
    tbl[10] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'd1};
    tbl[11] = '{1'b1, 3'b001, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 32'd2};
    tbl[12] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2};
    tbl[13] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2};
    tbl[14] = '{1'b1, 3'b100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2};
    tbl[15] = '{1'b0, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 32'd2};
    tbl[16] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 32'd2};
    tbl[17] = '{1'b1, 3'b010, 1'b1, 3'b000, 1'b0, 1'b0, 1'b1, 32'd2};
    tbl[18] = '{1'b0, 3'b001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'd2};
    tbl[19] = '{1'b1, 3'b010, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 32'd2};

    rst_n = 1'b0; i_arm = 1'b0; i_btn = '0; i_close = 1'b0;
    @(negedge clk);
    do_reset();

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].arm, tbl[i].btn, tbl[i].close);
      chk($sformatf("tbl%0d.vote", i),   32'(o_vote),   32'(tbl[i].vote));
      chk($sformatf("tbl%0d.ready", i),  32'(o_ready),  32'(tbl[i].ready));
      chk($sformatf("tbl%0d.reject", i), 32'(o_reject), 32'(tbl[i].rej));
      chk($sformatf("tbl%0d.over", i),   32'(o_over),   32'(tbl[i].over));
      chk($sformatf("tbl%0d.total", i),  o_total,       tbl[i].total);
    end

    // Close sampled during the commit cycle: the vote still counts.
    do_reset();
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b0, 3'b100, 1'b0);
    chk("cc.vote", 32'(o_vote), 32'b100);
    chk("cc.total", o_total, 32'd1);
    drive(1'b0, 3'b100, 1'b1);
    chk("cc.over", 32'(o_over), 32'd1);
    chk("cc.vote_after", 32'(o_vote), 32'd0);
    chk("cc.total_after", o_total, 32'd1);

    // Reset landing in the commit cycle clears pulse and total.
    do_reset();
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b0, 3'b001, 1'b0);
    chk("rc.vote", 32'(o_vote), 32'b001);
    do_reset();

    // Arm held high across sessions must not re-arm.
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b010, 1'b0);
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b001, 1'b0);
    chk("hold.vote", 32'(o_vote), 32'd0);
    drive(1'b1, 3'b000, 1'b0);
    chk("hold.total", o_total, 32'd1);
    chk("hold.ready", 32'(o_ready), 32'd0);
    drive(1'b0, 3'b000, 1'b0);
    drive(1'b1, 3'b000, 1'b0);
    drive(1'b1, 3'b100, 1'b0);
    chk("rearm.vote", 32'(o_vote), 32'b100);
    chk("rearm.total", o_total, 32'd2);

    // Idle ARMED session.
    do_reset();
    drive(1'b1, 3'b000, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      drive(1'b1, 3'b000, 1'b0);
`ifdef VOTE_TIMEOUT_EN
      chk($sformatf("to%0d.timeout", k), 32'(o_timeout), 32'(k == int'(TO_CYC)));
      chk($sformatf("to%0d.ready", k),   32'(o_ready),   32'(k < int'(TO_CYC)));
`else
      chk($sformatf("to%0d.timeout", k), 32'(o_timeout), 32'd0);
      chk($sformatf("to%0d.ready", k),   32'(o_ready),   32'd1);
`endif
    end

    // Randomized traffic against the reference model.
    do_reset();
    begin
      logic       a;
      logic [2:0] b;
      logic       c;
      int         r;
      a = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
        if (cyc % 250 == 249) do_reset();
        if ($urandom_range(0, 3) == 0) a = ~a;
        r = $urandom_range(0, 9);
        if (r < 5)      b = 3'b000;
        else if (r < 8) b = 3'(1 << $urandom_range(0, 2));
        else            b = 3'($urandom_range(0, 7));
        c = ($urandom_range(0, 199) == 0);
        drive(a, b, c);
        chk_model($sformatf("rand%0d", cyc));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
